// File: rtl/chacha20_decryption_if.sv
// Job/result handshake bundle for the ChaCha20 decryption block.
// Optional build macro: CHACHA20_DEC_AUTO_CTR_EN adds in_first to the bundle.
interface chacha20_decryption_if;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned NONCE_W = 96;
  localparam int unsigned CTR_W   = 32;
  localparam int unsigned BLK_W   = 512;

  logic               in_valid;
  logic               in_ready;
  logic [KEY_W-1:0]   key;
  logic [NONCE_W-1:0] nonce;
  logic [CTR_W-1:0]   counter;
  logic [BLK_W-1:0]   ciphertext;
  logic               out_valid;
  logic               out_ready;
  logic [BLK_W-1:0]   plaintext;
`ifdef CHACHA20_DEC_AUTO_CTR_EN
  logic               in_first;
`endif

  // Source / sink side
  modport master (
`ifdef CHACHA20_DEC_AUTO_CTR_EN
    output in_first,
`endif
    output in_valid, key, nonce, counter, ciphertext, out_ready,
    input  in_ready, out_valid, plaintext
  );

  // Decryption block side
  modport slave (
`ifdef CHACHA20_DEC_AUTO_CTR_EN
    input  in_first,
`endif
    input  in_valid, key, nonce, counter, ciphertext, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/chacha20_decryption.sv
// ChaCha20 decryption: regenerates one keystream block (one round per clock)
// and XORs it with the captured ciphertext block.
// Optional build macro: CHACHA20_DEC_AUTO_CTR_EN (in_first selects stored
// key/nonce with auto-incremented counter for follow-on blocks).
module chacha20_decryption #(
  parameter int unsigned ROUNDS = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  chacha20_decryption_if.slave    bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned BLK_W  = 512;
  localparam int unsigned CNT_W  = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               rnd;
  logic [NWORDS-1:0][WORD_W-1:0]  x, x_nxt, init, init_ld;
  logic [BLK_W-1:0]               ct, pt_nxt;
  logic [255:0]                   key_eff;
  logic [95:0]                    nonce_eff;
  logic [31:0]                    ctr_eff;
  logic                           accept, last, drain;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

`ifdef CHACHA20_DEC_AUTO_CTR_EN
  logic [255:0] key_q;
  logic [95:0]  nonce_q;
  logic [31:0]  ctr_q;

  // Follow-on blocks reuse the stored key/nonce with the next counter
  always_comb begin
    key_eff   = bus.key;
    nonce_eff = bus.nonce;
    ctr_eff   = bus.counter;
    if (!bus.in_first) begin
      key_eff   = key_q;
      nonce_eff = nonce_q;
      ctr_eff   = ctr_q + 32'd1;
    end
  end

  // Remember the parameters of every accepted job
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
    end else if (accept) begin
      key_q   <= key_eff;
      nonce_q <= nonce_eff;
      ctr_q   <= ctr_eff;
    end
  end
`else
  assign key_eff   = bus.key;
  assign nonce_eff = bus.nonce;
  assign ctr_eff   = bus.counter;
`endif

  // Initial ChaCha20 state from constants, key, counter and nonce
  always_comb begin
    init_ld     = '0;
    init_ld[0]  = 32'h61707865;
    init_ld[1]  = 32'h3320646e;
    init_ld[2]  = 32'h79622d32;
    init_ld[3]  = 32'h6b206574;
    for (int unsigned i = 0; i < 8; i++)
      init_ld[4'(4 + i)] = key_eff[255 - 32*i -: 32];
    init_ld[12] = ctr_eff;
    init_ld[13] = nonce_eff[95:64];
    init_ld[14] = nonce_eff[63:32];
    init_ld[15] = nonce_eff[31:0];
  end

  // One round: column set on even counts, diagonal set on odd counts
  always_comb begin
    x_nxt = x;
    if (!rnd[0]) begin
      {x_nxt[0], x_nxt[4], x_nxt[8],  x_nxt[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x_nxt[1], x_nxt[5], x_nxt[9],  x_nxt[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x_nxt[2], x_nxt[6], x_nxt[10], x_nxt[14]} = qr(x[2], x[6], x[10], x[14]);
      {x_nxt[3], x_nxt[7], x_nxt[11], x_nxt[15]} = qr(x[3], x[7], x[11], x[15]);
    end else begin
      {x_nxt[0], x_nxt[5], x_nxt[10], x_nxt[15]} = qr(x[0], x[5], x[10], x[15]);
      {x_nxt[1], x_nxt[6], x_nxt[11], x_nxt[12]} = qr(x[1], x[6], x[11], x[12]);
      {x_nxt[2], x_nxt[7], x_nxt[8],  x_nxt[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x_nxt[3], x_nxt[4], x_nxt[9],  x_nxt[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
  end

  // Feed-forward add and XOR with ciphertext; word 0 lands in the top bits
  always_comb begin
    pt_nxt = '0;
    for (int unsigned i = 0; i < NWORDS; i++)
      pt_nxt[BLK_W - 1 - 32*i -: 32] = ct[BLK_W - 1 - 32*i -: 32] ^ (x_nxt[4'(i)] + init[4'(i)]);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (last)   state_nxt = DONE;
      DONE:    if (drain)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from state and handshakes
  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    drain  = 1'b0;
    case (state)
      IDLE:    accept = bus.in_valid && bus.in_ready;
      ROUND:   last   = (rnd == CNT_W'(ROUNDS - 1));
      DONE:    drain  = bus.out_valid && bus.out_ready;
      default: ;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x             <= '0;
      init          <= '0;
      ct            <= '0;
      rnd           <= '0;
      bus.plaintext <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b0;
    end else begin
      bus.in_ready <= (state_nxt == IDLE);
      if (accept) begin
        x    <= init_ld;
        init <= init_ld;
        ct   <= bus.ciphertext;
        rnd  <= '0;
      end else if (state == ROUND) begin
        x   <= x_nxt;
        rnd <= rnd + CNT_W'(1);
        if (last) begin
          bus.plaintext <= pt_nxt;
          bus.out_valid <= 1'b1;
        end
      end
      if (drain) bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_chacha20_decryption.sv
// Directed self-checking bench for chacha20_decryption.
// Optional build macro: CHACHA20_DEC_AUTO_CTR_EN enables the auto-counter steps.
module tb_chacha20_decryption;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  localparam logic [255:0] KAT_KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
  localparam logic [95:0]  KAT_NONCE = {32'h09000000, 32'h4a000000, 32'h00000000};
  localparam logic [511:0] KAT_KS = {32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                                     32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                                     32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                                     32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
  localparam logic [511:0] PAT_A5 = {64{8'hA5}};

  always #5 clk = ~clk;

  chacha20_decryption_if bus();

  chacha20_decryption #(.ROUNDS(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] m_rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] m_qr(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0, input logic [31:0] d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a += b; d ^= a; d = m_rotl(d, 16);
    c += d; b ^= c; b = m_rotl(b, 12);
    a += b; d ^= a; d = m_rotl(d, 8);
    c += d; b ^= c; b = m_rotl(b, 7);
    return {a, b, c, d};
  endfunction

  // Reference ChaCha20 block function (20 rounds) serialised s0 at the top
  function automatic logic [511:0] model_ks(input logic [255:0] k, input logic [95:0] n,
                                            input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  w [16];
    logic [127:0] t;
    logic [511:0] r;
    int ia, ib, ic, id;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[255 - 32*i -: 32];
    s[12] = c; s[13] = n[95:64]; s[14] = n[63:32]; s[15] = n[31:0];
    w = s;
    for (int dr = 0; dr < 10; dr++) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int j = 0; j < 4; j++) begin
          ia = j;
          ib = 4  + ((pass == 0) ? j : (j + 1) % 4);
          ic = 8  + ((pass == 0) ? j : (j + 2) % 4);
          id = 12 + ((pass == 0) ? j : (j + 3) % 4);
          t = m_qr(w[ia], w[ib], w[ic], w[id]);
          w[ia] = t[127:96]; w[ib] = t[95:64]; w[ic] = t[63:32]; w[id] = t[31:0];
        end
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = w[i] + s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!bus.in_ready && g < 100) begin
      step();
      g++;
    end
    chk("accept_wait", 512'(bus.in_ready), 512'(1));
  endtask

  task automatic send(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                      input logic [511:0] ctext);
    bus.key = k; bus.nonce = n; bus.counter = c; bus.ciphertext = ctext;
    bus.in_valid = 1'b1;
    wait_ready();
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int           lat;
    int           busy;
    int           g;
    logic         ok;
    logic [511:0] ctr_rand;
    logic [511:0] ctb;

    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.key        = '0;
    bus.nonce      = '0;
    bus.counter    = '0;
    bus.ciphertext = '0;
    bus.out_ready  = 1'b0;
`ifdef CHACHA20_DEC_AUTO_CTR_EN
    bus.in_first   = 1'b1;
`endif
    ctr_rand = {16{$urandom()}};
    ctb      = {16{$urandom()}};

    // Reset values
    #12;
    chk("rst_in_ready",  512'(bus.in_ready),  512'(0));
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_plaintext", bus.plaintext, '0);
    reset_n = 1'b1;
    step(); step();
    chk("idle_in_ready", 512'(bus.in_ready), 512'(1));

    // Known answer, latency, drain
    bus.out_ready = 1'b1;
    send(KAT_KEY, KAT_NONCE, 32'd1, '0);
    wait_out(lat);
    chk("kat_latency", 512'(lat), 512'(20));
    chk("kat_pt", bus.plaintext, KAT_KS);
    step();
    chk("drain_out_valid", 512'(bus.out_valid), 512'(0));
    chk("drain_in_ready",  512'(bus.in_ready),  512'(1));

    // Ciphertext equal to keystream, and keystream ^ A5
    send(KAT_KEY, KAT_NONCE, 32'd1, KAT_KS);
    wait_out(lat);
    chk("ct_is_ks_zero", bus.plaintext, '0);
    step();
    send(KAT_KEY, KAT_NONCE, 32'd1, KAT_KS ^ PAT_A5);
    wait_out(lat);
    chk("ct_a5", bus.plaintext, PAT_A5);
    step();

    // Counter at its maximum value
    send(KAT_KEY, KAT_NONCE, 32'hFFFFFFFF, ctr_rand);
    wait_out(lat);
    chk("ctr_max", bus.plaintext, model_ks(KAT_KEY, KAT_NONCE, 32'hFFFFFFFF) ^ ctr_rand);
    step();

    // Backpressure
    bus.out_ready = 1'b0;
    send(KAT_KEY, KAT_NONCE, 32'd1, '0);
    wait_out(lat);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.plaintext !== KAT_KS || bus.in_ready !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", 512'(ok), 512'(1));
    bus.out_ready = 1'b1;
    step();
    chk("bp_drain_valid", 512'(bus.out_valid), 512'(0));
    chk("bp_in_ready",    512'(bus.in_ready),  512'(1));

    // Reset in the middle of the rounds
    send(KAT_KEY, KAT_NONCE, 32'd1, '0);
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0;
    #1;
    chk("rst_round_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_round_pt",    bus.plaintext, '0);
    chk("rst_round_ready", 512'(bus.in_ready), 512'(0));
    #2 reset_n = 1'b1;
    step(); step();
    send(KAT_KEY, KAT_NONCE, 32'd1, '0);
    wait_out(lat);
    chk("post_rst_latency", 512'(lat), 512'(20));
    chk("post_rst_pt", bus.plaintext, KAT_KS);
    step();

    // Reset while holding a result
    bus.out_ready = 1'b0;
    send(KAT_KEY, KAT_NONCE, 32'd1, PAT_A5);
    wait_out(lat);
    reset_n = 1'b0;
    #1;
    chk("rst_done_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_done_pt",    bus.plaintext, '0);
    #2 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("no_stale_output", 512'(ok), 512'(1));

    // in_valid held while busy with changing inputs, then a back-to-back job
    bus.key = KAT_KEY; bus.nonce = KAT_NONCE; bus.counter = 32'd1; bus.ciphertext = '0;
    bus.in_valid = 1'b1;
    wait_ready();
    step();
    busy = 0;
    if (!bus.in_ready) busy++;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      bus.key        = {8{$urandom()}};
      bus.counter    = $urandom();
      bus.ciphertext = {16{$urandom()}};
      step();
      lat++;
      if (!bus.in_ready) busy++;
    end
    chk("busy_latency", 512'(lat), 512'(20));
    chk("busy_first_pt", bus.plaintext, KAT_KS);
    bus.key = KAT_KEY; bus.nonce = KAT_NONCE; bus.counter = 32'd7; bus.ciphertext = ctb;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      step();
      g++;
      if (!bus.in_ready) busy++;
    end
    chk("busy_cycles", 512'(busy), 512'(21));
    chk("no_drain_accept_overlap", 512'(bus.out_valid), 512'(0));
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_latency", 512'(lat), 512'(20));
    chk("b2b_pt", bus.plaintext, model_ks(KAT_KEY, KAT_NONCE, 32'd7) ^ ctb);
    step();

`ifdef CHACHA20_DEC_AUTO_CTR_EN
    // Auto counter: wrap from FFFFFFFF, then 1 -> 2 -> 3
    bus.in_first = 1'b1;
    send(KAT_KEY, KAT_NONCE, 32'hFFFFFFFF, '0);
    wait_out(lat);
    chk("auto_first_max", bus.plaintext, model_ks(KAT_KEY, KAT_NONCE, 32'hFFFFFFFF));
    step();
    bus.in_first = 1'b0;
    send({8{32'hdeadbeef}}, {3{32'h12345678}}, 32'h00001234, '0);
    wait_out(lat);
    chk("auto_wrap", bus.plaintext, model_ks(KAT_KEY, KAT_NONCE, 32'h0));
    step();
    bus.in_first = 1'b1;
    send(KAT_KEY, KAT_NONCE, 32'd1, '0);
    wait_out(lat);
    chk("auto_first_1", bus.plaintext, KAT_KS);
    step();
    bus.in_first = 1'b0;
    send({8{32'h0badf00d}}, {3{32'h55aa55aa}}, 32'h00000099, PAT_A5);
    wait_out(lat);
    chk("auto_ctr2", bus.plaintext, model_ks(KAT_KEY, KAT_NONCE, 32'd2) ^ PAT_A5);
    step();
    send('0, '0, '0, '0);
    wait_out(lat);
    chk("auto_ctr3", bus.plaintext, model_ks(KAT_KEY, KAT_NONCE, 32'd3));
    step();
    bus.in_first = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
